// File: rtl/ddr_data_core_if.sv
// ddr_data_core_if
//   Groups the three AXI-Stream style output channels of ddr_data_core.
//   m_axis_tdata/tvalid/tready                       256-bit RNG words to the DDR writer
//   m_axis_tdata_gc/tvalid_gc/tready_gc              64-bit click records to XDMA
//   m_axis_tdata_alpha/tvalid_alpha/tready_alpha     128-bit alpha words to the host
//   master: data source (the core), slave: data sink.
interface ddr_data_core_if;
    logic [255:0] m_axis_tdata;
    logic         m_axis_tvalid;
    logic         m_axis_tready;
    logic [63:0]  m_axis_tdata_gc;
    logic         m_axis_tvalid_gc;
    logic         m_axis_tready_gc;
    logic [127:0] m_axis_tdata_alpha;
    logic         m_axis_tvalid_alpha;
    logic         m_axis_tready_alpha;

    modport master (
        output m_axis_tdata, m_axis_tvalid, input m_axis_tready,
        output m_axis_tdata_gc, m_axis_tvalid_gc, input m_axis_tready_gc,
        output m_axis_tdata_alpha, m_axis_tvalid_alpha, input m_axis_tready_alpha
    );

    modport slave (
        input m_axis_tdata, m_axis_tvalid, output m_axis_tready,
        input m_axis_tdata_gc, m_axis_tvalid_gc, output m_axis_tready_gc,
        input m_axis_tdata_alpha, m_axis_tvalid_alpha, output m_axis_tready_alpha
    );
endinterface

// File: rtl/ddr_data_core.sv
// ddr_data_core
//   QKD transmitter data path on the 200 MHz clock. Counts global qubit slots, packs 4-bit RNG
//   symbols into 256-bit words and 2-bit alpha symbols into 128-bit words, and tags detector
//   clicks with the delay-compensated slot number into a small record FIFO.
//   Ports: clk200_i / ddr_data_rstn (async active-low), pps_i, rd_en_4 slot strobe, rng_data,
//   rng_a_data, tvalid200/tdata200_mod click input, gate_pos0..3 gate windows, sr_* control
//   and status registers, axis = output stream channels (master modport).
//
//   state | meaning
//   IDLE  | stopped, counter holds its last value
//   ARMED | enabled, waiting for pps rising edge
//   RUN   | counting slots, packing symbols, tagging clicks
module ddr_data_core #(
    parameter int GC_FIFO_DEPTH = 16
) (
    input  logic                 clk200_i,
    input  logic                 ddr_data_rstn,
    input  logic                 pps_i,
    input  logic                 rd_en_4,
    input  logic [3:0]           rng_data,
    input  logic [1:0]           rng_a_data,
    input  logic                 tvalid200,
    input  logic [15:0]          tdata200_mod,
    input  logic [31:0]          gate_pos0,
    input  logic [31:0]          gate_pos1,
    input  logic [31:0]          gate_pos2,
    input  logic [31:0]          gate_pos3,
    input  logic                 sr_start_write_ddr_i,
    input  logic                 sr_command_gc_enable,
    input  logic                 sr_command_alpha_enable,
    input  logic [47:0]          sr_dq_gc_start_i,
    input  logic [15:0]          sr_fiber_delay_i,
    output logic [47:0]          sr_current_dq_gc,
    ddr_data_core_if.master      axis
);
    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] ARMED = 2'd1;
    localparam logic [1:0] RUN   = 2'd2;
    localparam int AW = $clog2(GC_FIFO_DEPTH);

    logic [1:0]   state_q, state_d;
    logic [47:0]  cnt_q, cnt_d;
    logic         pps_q;
    logic         go, pps_rise, run;

    logic [255:0] rng_word_q, rng_tdata_q;
    logic [5:0]   rng_idx_q;
    logic         rng_tvalid_q;
    logic [127:0] alpha_word_q, alpha_tdata_q;
    logic [5:0]   alpha_idx_q;
    logic         alpha_tvalid_q;

    logic [63:0]  fifo_mem [GC_FIFO_DEPTH];
    logic [AW:0]  wr_ptr_q, rd_ptr_q;
    logic         fifo_empty, fifo_full, push, pop;
    logic [1:0]   click;
    logic [31:0]  mod_ext;

    assign go       = sr_start_write_ddr_i && sr_command_gc_enable;
    assign pps_rise = pps_i && !pps_q;
    assign run      = (state_q == RUN) && go;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        if (!go) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE:  state_d = ARMED;
                ARMED: if (pps_rise) begin
                    state_d = RUN;
                    cnt_d   = sr_dq_gc_start_i;
                end
                RUN:   if (rd_en_4) cnt_d = cnt_q + 48'd1;
                default: state_d = IDLE;
            endcase
        end
    end

    assign mod_ext    = {16'd0, tdata200_mod};
    assign click[0]   = (gate_pos0 <= mod_ext) && (mod_ext < gate_pos1);
    assign click[1]   = (gate_pos2 <= mod_ext) && (mod_ext < gate_pos3);
    assign fifo_empty = (wr_ptr_q == rd_ptr_q);
    assign fifo_full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                        (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign push       = run && tvalid200 && (click != 2'b00) && !fifo_full;
    assign pop        = !fifo_empty && axis.m_axis_tready_gc;

    always_ff @(posedge clk200_i or negedge ddr_data_rstn) begin
        if (!ddr_data_rstn) begin
            state_q        <= IDLE;
            cnt_q          <= '0;
            pps_q          <= 1'b0;
            rng_word_q     <= '0;
            rng_tdata_q    <= '0;
            rng_idx_q      <= '0;
            rng_tvalid_q   <= 1'b0;
            alpha_word_q   <= '0;
            alpha_tdata_q  <= '0;
            alpha_idx_q    <= '0;
            alpha_tvalid_q <= 1'b0;
            wr_ptr_q       <= '0;
            rd_ptr_q       <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            pps_q   <= pps_i;

            if (rng_tvalid_q && axis.m_axis_tready) rng_tvalid_q <= 1'b0;
            if (!run) begin
                rng_idx_q  <= '0;
                rng_word_q <= '0;
            end else if (rd_en_4) begin
                rng_word_q[{rng_idx_q, 2'b00} +: 4] <= rng_data;
                rng_idx_q <= rng_idx_q + 6'd1;
                // Completed word is dropped if the previous one is still waiting.
                if (rng_idx_q == 6'd63 && (!rng_tvalid_q || axis.m_axis_tready)) begin
                    rng_tdata_q  <= {rng_data, rng_word_q[251:0]};
                    rng_tvalid_q <= 1'b1;
                end
            end

            if (alpha_tvalid_q && axis.m_axis_tready_alpha) alpha_tvalid_q <= 1'b0;
            if (!run || !sr_command_alpha_enable) begin
                alpha_idx_q  <= '0;
                alpha_word_q <= '0;
            end else if (rd_en_4) begin
                alpha_word_q[{alpha_idx_q, 1'b0} +: 2] <= rng_a_data;
                alpha_idx_q <= alpha_idx_q + 6'd1;
                if (alpha_idx_q == 6'd63 && (!alpha_tvalid_q || axis.m_axis_tready_alpha)) begin
                    alpha_tdata_q  <= {rng_a_data, alpha_word_q[125:0]};
                    alpha_tvalid_q <= 1'b1;
                end
            end

            if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
        end
    end

    // Storage needs no reset: the read side is masked while the FIFO is empty.
    always_ff @(posedge clk200_i) begin
        if (push) fifo_mem[wr_ptr_q[AW-1:0]] <= {14'd0, click, cnt_q - {32'd0, sr_fiber_delay_i}};
    end

    assign sr_current_dq_gc          = cnt_q;
    assign axis.m_axis_tdata         = rng_tdata_q;
    assign axis.m_axis_tvalid        = rng_tvalid_q;
    assign axis.m_axis_tdata_alpha   = alpha_tdata_q;
    assign axis.m_axis_tvalid_alpha  = alpha_tvalid_q;
    assign axis.m_axis_tvalid_gc     = !fifo_empty;
    assign axis.m_axis_tdata_gc      = fifo_empty ? 64'd0 : fifo_mem[rd_ptr_q[AW-1:0]];
endmodule

// File: tb/tb_ddr_data_core.sv
// tb_ddr_data_core
//   Directed bench for ddr_data_core: reset, slot counting, RNG/alpha packing, click tagging,
//   FIFO overflow/drain, and async reset with a pending beat.
module tb_ddr_data_core;
    logic        clk = 1'b0;
    logic        rstn = 1'b0;
    logic        pps = 1'b0, rd_en_4 = 1'b0, tvalid200 = 1'b0;
    logic [3:0]  rng_data = '0;
    logic [1:0]  rng_a_data = '0;
    logic [15:0] mod = '0;
    logic [31:0] g0 = '0, g1 = '0, g2 = '0, g3 = '0;
    logic        start = 1'b0, gc_en = 1'b0, alpha_en = 1'b0;
    logic [47:0] dq_start = '0;
    logic [15:0] fiber = '0;
    logic [47:0] cur_gc;
    int          n_vec = 0;
    int          n_err = 0;

    ddr_data_core_if axis ();

    ddr_data_core #(.GC_FIFO_DEPTH(16)) dut (
        .clk200_i(clk), .ddr_data_rstn(rstn), .pps_i(pps), .rd_en_4(rd_en_4),
        .rng_data(rng_data), .rng_a_data(rng_a_data), .tvalid200(tvalid200),
        .tdata200_mod(mod), .gate_pos0(g0), .gate_pos1(g1), .gate_pos2(g2), .gate_pos3(g3),
        .sr_start_write_ddr_i(start), .sr_command_gc_enable(gc_en),
        .sr_command_alpha_enable(alpha_en), .sr_dq_gc_start_i(dq_start),
        .sr_fiber_delay_i(fiber), .sr_current_dq_gc(cur_gc), .axis(axis.master)
    );

    always #5 clk = ~clk;

    task automatic strobe(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk) rd_en_4 = 1'b1;
            @(negedge clk) rd_en_4 = 1'b0;
        end
    endtask

    task automatic go_run(input logic [47:0] v);
        @(negedge clk) start = 1'b0;
        @(negedge clk) begin start = 1'b1; gc_en = 1'b1; dq_start = v; end
        @(negedge clk) pps = 1'b1;
        @(negedge clk) pps = 1'b0;
    endtask

    task automatic click_at(input logic [15:0] m);
        @(negedge clk) begin tvalid200 = 1'b1; mod = m; end
        @(negedge clk) tvalid200 = 1'b0;
    endtask

    task automatic test_reset;
        #12;
        n_vec++; if (axis.m_axis_tvalid !== 1'b0) begin n_err++; $display("FAIL rst_tvalid got %b want 0", axis.m_axis_tvalid); end
        n_vec++; if (axis.m_axis_tvalid_gc !== 1'b0) begin n_err++; $display("FAIL rst_tvalid_gc got %b want 0", axis.m_axis_tvalid_gc); end
        n_vec++; if (axis.m_axis_tvalid_alpha !== 1'b0) begin n_err++; $display("FAIL rst_tvalid_alpha got %b want 0", axis.m_axis_tvalid_alpha); end
        n_vec++; if (cur_gc !== 48'd0) begin n_err++; $display("FAIL rst_counter got %h want 0", cur_gc); end
        @(negedge clk) rstn = 1'b1;
        @(negedge clk) begin start = 1'b1; gc_en = 1'b0; dq_start = 48'h777; end
        @(negedge clk) pps = 1'b1;
        @(negedge clk) pps = 1'b0;
        strobe(3);
        n_vec++; if (cur_gc !== 48'd0) begin n_err++; $display("FAIL gc_disabled_counter got %h want 0", cur_gc); end
    endtask

    task automatic test_count;
        go_run(48'h433);
        n_vec++; if (cur_gc !== 48'h433) begin n_err++; $display("FAIL count_load got %h want 433", cur_gc); end
        strobe(10);
        n_vec++; if (cur_gc !== 48'h43D) begin n_err++; $display("FAIL count_10 got %h want 43d", cur_gc); end
        @(negedge clk) start = 1'b0;
        strobe(2);
        n_vec++; if (cur_gc !== 48'h43D) begin n_err++; $display("FAIL count_hold_idle got %h want 43d", cur_gc); end
    endtask

    task automatic test_rng_pack;
        logic [255:0] exp_w;
        int beats;
        exp_w = {64{4'h1}};
        axis.m_axis_tready = 1'b0;
        rng_data = 4'h1;
        go_run(48'h0);
        strobe(63);
        n_vec++; if (axis.m_axis_tvalid !== 1'b0) begin n_err++; $display("FAIL rng_63_no_beat got %b want 0", axis.m_axis_tvalid); end
        strobe(1);
        n_vec++; if (axis.m_axis_tvalid !== 1'b1) begin n_err++; $display("FAIL rng_valid got %b want 1", axis.m_axis_tvalid); end
        n_vec++; if (axis.m_axis_tdata !== exp_w) begin n_err++; $display("FAIL rng_data got %h want %h", axis.m_axis_tdata, exp_w); end
        rng_data = 4'h2;
        strobe(64);
        n_vec++; if (axis.m_axis_tvalid !== 1'b1) begin n_err++; $display("FAIL rng_held_valid got %b want 1", axis.m_axis_tvalid); end
        n_vec++; if (axis.m_axis_tdata !== exp_w) begin n_err++; $display("FAIL rng_drop_held got %h want %h", axis.m_axis_tdata, exp_w); end
        axis.m_axis_tready = 1'b1;
        beats = 0;
        for (int i = 0; i < 6; i++) begin
            if (axis.m_axis_tvalid && axis.m_axis_tready) beats++;
            @(negedge clk);
        end
        n_vec++; if (beats !== 1) begin n_err++; $display("FAIL rng_one_beat got %0d want 1", beats); end
        n_vec++; if (axis.m_axis_tvalid !== 1'b0) begin n_err++; $display("FAIL rng_drained got %b want 0", axis.m_axis_tvalid); end
    endtask

    task automatic test_click;
        axis.m_axis_tready_gc = 1'b1;
        fiber = 16'd0;
        g0 = 32'd0; g1 = 32'd400; g2 = 32'd400; g3 = 32'd625;
        go_run(48'h500);
        click_at(16'd100);
        n_vec++; if (axis.m_axis_tvalid_gc !== 1'b1) begin n_err++; $display("FAIL click100_valid got %b want 1", axis.m_axis_tvalid_gc); end
        n_vec++; if (axis.m_axis_tdata_gc !== {14'd0, 2'b01, 48'h500}) begin n_err++; $display("FAIL click100_data got %h want %h", axis.m_axis_tdata_gc, {14'd0, 2'b01, 48'h500}); end
        click_at(16'd500);
        n_vec++; if (axis.m_axis_tdata_gc !== {14'd0, 2'b10, 48'h500}) begin n_err++; $display("FAIL click500_data got %h want %h", axis.m_axis_tdata_gc, {14'd0, 2'b10, 48'h500}); end
        click_at(16'd400);
        n_vec++; if (axis.m_axis_tdata_gc !== {14'd0, 2'b10, 48'h500}) begin n_err++; $display("FAIL click400_edge got %h want %h", axis.m_axis_tdata_gc, {14'd0, 2'b10, 48'h500}); end
        click_at(16'd700);
        n_vec++; if (axis.m_axis_tvalid_gc !== 1'b0) begin n_err++; $display("FAIL click700_none got %b want 0", axis.m_axis_tvalid_gc); end
        click_at(16'd625);
        n_vec++; if (axis.m_axis_tvalid_gc !== 1'b0) begin n_err++; $display("FAIL click625_none got %b want 0", axis.m_axis_tvalid_gc); end
        fiber = 16'd3;
        click_at(16'd100);
        n_vec++; if (axis.m_axis_tdata_gc !== {14'd0, 2'b01, 48'h4FD}) begin n_err++; $display("FAIL click_fiber got %h want %h", axis.m_axis_tdata_gc, {14'd0, 2'b01, 48'h4FD}); end
        @(negedge clk);
        n_vec++; if (axis.m_axis_tvalid_gc !== 1'b0) begin n_err++; $display("FAIL click_popped got %b want 0", axis.m_axis_tvalid_gc); end
        fiber = 16'd0;
    endtask

    task automatic test_fifo_full;
        logic [63:0] exp_r;
        axis.m_axis_tready_gc = 1'b0;
        go_run(48'h1000);
        for (int i = 0; i < 17; i++) begin
            @(negedge clk) begin tvalid200 = 1'b1; rd_en_4 = 1'b1; mod = 16'd100; end
        end
        @(negedge clk) begin tvalid200 = 1'b0; rd_en_4 = 1'b0; end
        n_vec++; if (cur_gc !== 48'h1011) begin n_err++; $display("FAIL fifo_counter got %h want 1011", cur_gc); end
        axis.m_axis_tready_gc = 1'b1;
        for (int i = 0; i < 16; i++) begin
            exp_r = {14'd0, 2'b01, 48'h1000 + 48'(i)};
            n_vec++; if (axis.m_axis_tvalid_gc !== 1'b1 || axis.m_axis_tdata_gc !== exp_r) begin
                n_err++; $display("FAIL fifo_beat%0d got v=%b %h want v=1 %h", i, axis.m_axis_tvalid_gc, axis.m_axis_tdata_gc, exp_r);
            end
            @(negedge clk);
        end
        n_vec++; if (axis.m_axis_tvalid_gc !== 1'b0) begin n_err++; $display("FAIL fifo_17th_dropped got %b want 0", axis.m_axis_tvalid_gc); end
    endtask

    task automatic test_alpha;
        logic [127:0] exp_a;
        axis.m_axis_tready_alpha = 1'b1;
        alpha_en = 1'b1;
        rng_a_data = 2'h3;
        go_run(48'h0);
        strobe(64);
        exp_a = {128{1'b1}};
        n_vec++; if (axis.m_axis_tvalid_alpha !== 1'b1 || axis.m_axis_tdata_alpha !== exp_a) begin
            n_err++; $display("FAIL alpha_word got v=%b %h want v=1 %h", axis.m_axis_tvalid_alpha, axis.m_axis_tdata_alpha, exp_a);
        end
        strobe(30);
        @(negedge clk) start = 1'b0;
        repeat (3) @(negedge clk);
        n_vec++; if (axis.m_axis_tvalid_alpha !== 1'b0) begin n_err++; $display("FAIL alpha_stop_no_beat got %b want 0", axis.m_axis_tvalid_alpha); end
        rng_a_data = 2'h1;
        go_run(48'h0);
        strobe(34);
        n_vec++; if (axis.m_axis_tvalid_alpha !== 1'b0) begin n_err++; $display("FAIL alpha_partial_discard got %b want 0", axis.m_axis_tvalid_alpha); end
        strobe(30);
        exp_a = {64{2'b01}};
        n_vec++; if (axis.m_axis_tvalid_alpha !== 1'b1 || axis.m_axis_tdata_alpha !== exp_a) begin
            n_err++; $display("FAIL alpha_word2 got v=%b %h want v=1 %h", axis.m_axis_tvalid_alpha, axis.m_axis_tdata_alpha, exp_a);
        end
        alpha_en = 1'b0;
    endtask

    task automatic test_async_reset;
        axis.m_axis_tready = 1'b0;
        rng_data = 4'hA;
        go_run(48'h55);
        strobe(64);
        n_vec++; if (axis.m_axis_tvalid !== 1'b1) begin n_err++; $display("FAIL arst_pending got %b want 1", axis.m_axis_tvalid); end
        #1 rstn = 1'b0;
        #1;
        n_vec++; if (axis.m_axis_tvalid !== 1'b0 || axis.m_axis_tdata !== 256'd0) begin
            n_err++; $display("FAIL arst_rng got v=%b %h want v=0 0", axis.m_axis_tvalid, axis.m_axis_tdata);
        end
        n_vec++; if (cur_gc !== 48'd0) begin n_err++; $display("FAIL arst_counter got %h want 0", cur_gc); end
        @(negedge clk) rstn = 1'b1;
    endtask

    initial begin
        axis.m_axis_tready = 1'b1;
        axis.m_axis_tready_gc = 1'b1;
        axis.m_axis_tready_alpha = 1'b1;
        test_reset();
        test_count();
        test_rng_pack();
        test_click();
        test_fifo_full();
        test_alpha();
        test_async_reset();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog timeout");
        $fatal(1);
    end
endmodule
